// File: rtl/snn_pkg.sv
// Shared FSM state encodings and slot-length helper for the spike serializer blocks.
package snn_pkg;

   localparam int unsigned STATE_W = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Cycles per synapse slot for a given weight width.
   function automatic int unsigned slot_len(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/slot_counter.sv
// Free-running cycle counter within one synapse slot; wraps after SLOT cycles.
module slot_counter
   import snn_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             en_i,
   output logic             tc_o,
   output logic [WIDTH-1:0] count_nxt_c
);

   localparam int unsigned SLOT = slot_len(WIDTH);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_q ? '0 : count_q + WIDTH'(1);
      end
      // Terminal count flags the last cycle of the slot being entered.
      tc_d = (count_d == WIDTH'(SLOT - 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign tc_o        = tc_q;
   assign count_nxt_c = count_d;

endmodule

// File: rtl/spike_serializer.sv
// Serializes per-synapse weights into a rate-coded spike train, one fixed-length slot per synapse.
module spike_serializer
   import snn_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned HEIGHT = 7
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              reset_circuit,
   input  logic                                              start,
   input  logic [HEIGHT-1:0]                                 pixels,
   input  logic [HEIGHT*WIDTH-1:0]                           weights,
   output logic                                              pixel_out,
   output logic                                              busy,
   output logic                                              done,
   output logic [$clog2(HEIGHT*slot_len(WIDTH)+1)-1:0]       spike_count
);

   localparam int unsigned SLOT    = slot_len(WIDTH);
   localparam int unsigned COUNT_W = $clog2(HEIGHT*SLOT+1);
   localparam int unsigned IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              slot_q, slot_d;
   logic [HEIGHT-1:0]             pix_q, pix_d;
   logic [HEIGHT-1:0][WIDTH-1:0]  w_q, w_d;
   logic                          pixel_out_q, pixel_out_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic [COUNT_W-1:0]            count_q, count_d, count_base;

   logic                          cnt_clear, cnt_en, cnt_tc;
   logic [WIDTH-1:0]              cyc_nxt;

   slot_counter #(
      .WIDTH (WIDTH)
   ) u_slot_counter (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clear_i     (cnt_clear),
      .en_i        (cnt_en),
      .tc_o        (cnt_tc),
      .count_nxt_c (cyc_nxt)
   );

   // Next-state, capture and slot sequencing; frame abort overrides everything.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      pix_d      = pix_q;
      w_d        = w_q;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
      count_base = count_q;
      if (!reset_circuit) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_LOAD;
                  count_base = '0;
               end
            end
            ST_LOAD: begin
               pix_d     = pixels;
               w_d       = weights;
               slot_d    = '0;
               cnt_clear = 1'b1;
               state_d   = ST_EMIT;
            end
            ST_EMIT: begin
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  if (slot_q == IDX_W'(HEIGHT - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     slot_d = slot_q + IDX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are computed for the cycle being entered so they line up with the state.
   always_comb begin
      pixel_out_d = 1'b0;
      if (state_d == ST_EMIT) begin
         pixel_out_d = pix_d[slot_d] & (cyc_nxt < w_d[slot_d]);
      end
      busy_d  = (state_d == ST_LOAD) || (state_d == ST_EMIT);
      done_d  = (state_d == ST_DONE);
      count_d = count_base + COUNT_W'(pixel_out_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         pix_q       <= '0;
         w_q         <= '0;
         pixel_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         pix_q       <= pix_d;
         w_q         <= w_d;
         pixel_out_q <= pixel_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         count_q     <= count_d;
      end
   end

   assign pixel_out   = pixel_out_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign spike_count = count_q;

endmodule

// File: tb/tb_spike_serializer.sv
// Self-checking bench for spike_serializer against a slot/cycle arithmetic model.
module tb_spike_serializer;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned HEIGHT   = 7;
   localparam int unsigned SLOT     = 255;
   localparam int unsigned EMIT_LEN = HEIGHT * SLOT;
   localparam int unsigned CW       = $clog2(EMIT_LEN + 1);
   localparam int unsigned WW       = HEIGHT * WIDTH;

   logic                 clk;
   logic                 rst;
   logic                 reset_circuit;
   logic                 start;
   logic [HEIGHT-1:0]    pixels;
   logic [WW-1:0]        weights;
   logic                 pixel_out;
   logic                 busy;
   logic                 done;
   logic [CW-1:0]        spike_count;

   int total;
   int bad;

   logic [HEIGHT-1:0] f_pix;
   int                f_w [HEIGHT];
   logic              obs [EMIT_LEN];

   spike_serializer #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .reset_circuit (reset_circuit),
      .start         (start),
      .pixels        (pixels),
      .weights       (weights),
      .pixel_out     (pixel_out),
      .busy          (busy),
      .done          (done),
      .spike_count   (spike_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic model_bit(input int k);
      int s;
      int c;
      s = k / SLOT;
      c = k % SLOT;
      return f_pix[s] && (c < f_w[s]);
   endfunction

   function automatic int model_total();
      int sum;
      sum = 0;
      for (int i = 0; i < HEIGHT; i++) if (f_pix[i]) sum += f_w[i];
      return sum;
   endfunction

   task automatic drive_frame_inputs();
      pixels = f_pix;
      for (int i = 0; i < HEIGHT; i++) weights[i*WIDTH +: WIDTH] = WIDTH'(f_w[i]);
   endtask

   // Runs one frame from IDLE (or from LOAD when already_loaded) through DONE to the IDLE cycle.
   task automatic run_frame(input string name, input bit hold_start, input bit already_loaded);
      int exp_cnt;
      int bad_spk;
      int bad_cnt;
      int bad_busy;
      logic exp_b;
      drive_frame_inputs();
      if (!already_loaded) begin
         start = 1'b1;
         step();
      end
      total++;
      if (busy !== 1'b1 || spike_count !== '0 || pixel_out !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s load: busy=%b cnt=%0d pix=%b done=%b want 1,0,0,0",
                  name, busy, spike_count, pixel_out, done);
      end
      if (!hold_start) start = 1'b0;
      step();
      exp_cnt  = 0;
      bad_spk  = -1;
      bad_cnt  = -1;
      bad_busy = -1;
      for (int k = 0; k < EMIT_LEN; k++) begin
         pixels  = HEIGHT'($urandom);
         weights = WW'({$urandom, $urandom});
         if (!hold_start) start = 1'($urandom);
         obs[k] = pixel_out;
         exp_b  = model_bit(k);
         if (exp_b) exp_cnt++;
         if (bad_spk < 0 && pixel_out !== exp_b) bad_spk = k;
         if (bad_cnt < 0 && spike_count !== CW'(exp_cnt)) bad_cnt = k;
         if (bad_busy < 0 && (busy !== 1'b1 || done !== 1'b0)) bad_busy = k;
         step();
      end
      total++;
      if (bad_spk >= 0) begin
         bad++;
         $display("FAIL %s stream: cycle %0d got %b want %b",
                  name, bad_spk, obs[bad_spk], model_bit(bad_spk));
      end
      total++;
      if (bad_cnt >= 0) begin
         bad++;
         $display("FAIL %s running count: first wrong at emit cycle %0d", name, bad_cnt);
      end
      total++;
      if (bad_busy >= 0) begin
         bad++;
         $display("FAIL %s busy/done in emit: first wrong at emit cycle %0d", name, bad_busy);
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || pixel_out !== 1'b0) begin
         bad++;
         $display("FAIL %s done state: done=%b busy=%b pix=%b want 1,0,0",
                  name, done, busy, pixel_out);
      end
      total++;
      if (spike_count !== CW'(model_total())) begin
         bad++;
         $display("FAIL %s final count: got %0d want %0d", name, spike_count, model_total());
      end
      start = hold_start ? 1'b1 : 1'b1 & 1'($urandom);
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || spike_count !== CW'(model_total())) begin
         bad++;
         $display("FAIL %s idle after done: done=%b busy=%b cnt=%0d want 0,0,%0d",
                  name, done, busy, spike_count, model_total());
      end
      if (!hold_start) start = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      reset_circuit = 1'b1;
      start         = 1'b0;
      pixels        = '0;
      weights       = '0;
      #2 rst = 1'b0;
      start = 1'b1;
      step();
      step();
      total++;
      if (pixel_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || spike_count !== '0) begin
         bad++;
         $display("FAIL reset values: pix=%b busy=%b done=%b cnt=%0d want all 0",
                  pixel_out, busy, done, spike_count);
      end
      rst   = 1'b1;
      start = 1'b0;
      step();
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle without start: busy=%b want 0", busy);
      end
   endtask

   task automatic test_all_max();
      int run;
      int best;
      f_pix = '1;
      for (int i = 0; i < HEIGHT; i++) f_w[i] = SLOT;
      run_frame("all_max", 1'b0, 1'b0);
      run  = 0;
      best = 0;
      for (int k = 0; k < EMIT_LEN; k++) begin
         run  = (obs[k] === 1'b1) ? run + 1 : 0;
         best = (run > best) ? run : best;
      end
      total++;
      if (best != 1785) begin
         bad++;
         $display("FAIL all_max run: longest spike run %0d want 1785", best);
      end
      total++;
      if (spike_count !== CW'(1785)) begin
         bad++;
         $display("FAIL all_max count: got %0d want 1785", spike_count);
      end
   endtask

   task automatic test_pattern();
      int loud;
      f_pix = 7'b1100011;
      for (int i = 0; i < HEIGHT; i++) f_w[i] = 10 * (i + 1);
      run_frame("pattern", 1'b0, 1'b0);
      total++;
      if (spike_count !== CW'(160)) begin
         bad++;
         $display("FAIL pattern count: got %0d want 160", spike_count);
      end
      loud = 0;
      for (int k = 510; k < 765; k++) if (obs[k] !== 1'b0) loud++;
      total++;
      if (loud != 0 || obs[509] !== 1'b0) begin
         bad++;
         $display("FAIL pattern slot2 silence: %0d spikes in 510..764, c509=%b want 0,0", loud, obs[509]);
      end
   endtask

   task automatic test_zero();
      int loud;
      f_pix = HEIGHT'($urandom);
      for (int i = 0; i < HEIGHT; i++) f_w[i] = 0;
      run_frame("zero_w", 1'b0, 1'b0);
      loud = 0;
      for (int k = 0; k < EMIT_LEN; k++) if (obs[k] !== 1'b0) loud++;
      total++;
      if (loud != 0 || spike_count !== '0) begin
         bad++;
         $display("FAIL zero_w silence: spikes=%0d cnt=%0d want 0,0", loud, spike_count);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         f_pix = HEIGHT'($urandom);
         for (int i = 0; i < HEIGHT; i++) begin
            case ($urandom_range(0, 3))
               0:       f_w[i] = 0;
               1:       f_w[i] = SLOT;
               default: f_w[i] = $urandom_range(1, SLOT - 1);
            endcase
         end
         run_frame("random", 1'b0, 1'b0);
      end
   endtask

   task automatic test_abort();
      f_pix = {HEIGHT'($urandom)} & ~HEIGHT'(3) | HEIGHT'(1);
      f_w[0] = 100;
      for (int i = 1; i < HEIGHT; i++) f_w[i] = $urandom_range(0, SLOT);
      drive_frame_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int k = 0; k < 300; k++) step();
      total++;
      if (spike_count !== CW'(100) || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort precondition: cnt=%0d busy=%b want 100,1", spike_count, busy);
      end
      reset_circuit = 1'b0;
      start         = 1'b1;
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || pixel_out !== 1'b0 || spike_count !== CW'(100)) begin
         bad++;
         $display("FAIL abort idle: busy=%b done=%b pix=%b cnt=%0d want 0,0,0,100",
                  busy, done, pixel_out, spike_count);
      end
      step();
      total++;
      if (busy !== 1'b0 || spike_count !== CW'(100)) begin
         bad++;
         $display("FAIL abort priority: busy=%b cnt=%0d want 0,100", busy, spike_count);
      end
      reset_circuit = 1'b1;
      start         = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort no done: cycle %0d done=%b busy=%b want 0,0", k, done, busy);
         end
      end
      f_pix = HEIGHT'($urandom);
      for (int i = 0; i < HEIGHT; i++) f_w[i] = $urandom_range(0, SLOT);
      run_frame("after_abort", 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      f_pix = '1;
      for (int i = 0; i < HEIGHT; i++) f_w[i] = SLOT;
      drive_frame_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int k = 0; k < 400; k++) step();
      total++;
      if (pixel_out !== 1'b1 || spike_count !== CW'(401)) begin
         bad++;
         $display("FAIL async precondition: pix=%b cnt=%0d want 1,401", pixel_out, spike_count);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (pixel_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || spike_count !== '0) begin
         bad++;
         $display("FAIL async reset: pix=%b busy=%b done=%b cnt=%0d want all 0",
                  pixel_out, busy, done, spike_count);
      end
      step();
      rst = 1'b1;
      step();
      step();
      total++;
      if (busy !== 1'b0 || pixel_out !== 1'b0) begin
         bad++;
         $display("FAIL async needs start: busy=%b pix=%b want 0,0", busy, pixel_out);
      end
      f_pix = HEIGHT'($urandom);
      for (int i = 0; i < HEIGHT; i++) f_w[i] = $urandom_range(0, SLOT);
      run_frame("after_rst", 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      f_pix = HEIGHT'($urandom);
      for (int i = 0; i < HEIGHT; i++) f_w[i] = $urandom_range(0, SLOT);
      run_frame("b2b_first", 1'b1, 1'b0);
      step();
      f_pix = HEIGHT'($urandom);
      for (int i = 0; i < HEIGHT; i++) f_w[i] = $urandom_range(0, SLOT);
      run_frame("b2b_second", 1'b1, 1'b1);
      start = 1'b0;
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL b2b stop: busy=%b done=%b want 0,0", busy, done);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_all_max();
      test_pattern();
      test_zero();
      test_random();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
